// File: rtl/act_sched_pkg.sv
// act_sched_pkg: shared types, limits and the configuration legality check
// for the activation-window sequencer.
package act_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    BEAT,
    DRAIN,
    ERR
  } state_t;

  localparam int PE_MAC   = 14;
  localparam int RAM_ROW  = 33;
  // Stride 1 reads 2*PE_MAC-1+k columns from one buffer word.
  localparam int K_MAX_S1 = 6;
  localparam int K_MAX_S2 = 7;

  function automatic logic cfg_illegal(input logic [2:0] k,
                                       input logic [1:0] s,
                                       input logic [7:0] h,
                                       input logic [5:0] c,
                                       input int         kmax_s1);
    cfg_illegal = (k == 3'd0) ||
                  !(s == 2'd1 || s == 2'd2) ||
                  (h < {5'd0, k}) ||
                  (c == 6'd0) ||
                  ((s == 2'd1) && (int'(k) > kmax_s1)) ||
                  ((s == 2'd2) && (int'(k) > K_MAX_S2));
  endfunction

endpackage

// File: rtl/act_sched_dly.sv
// act_sched_dly: LAT-deep resettable shift register aligning the
// {acc_first, acc_last} sideband with the selector's out_valid.
//   clk_i  clock
//   rst_i  synchronous active-high reset, clears every stage
//   d_i    flags generated at beat time
//   q_o    flags delayed by LAT cycles
module act_sched_dly #(
  parameter int LAT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [1:0] sr_q [LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < LAT; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int unsigned i = 1; i < LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[LAT-1];

endmodule

// File: rtl/act_sched.sv
// act_sched: walks one layer of the activation line buffer (output row,
// kernel row, channel block, half, beat), issuing buffer reads, selector
// beats/half toggles and out_valid-aligned first/last row flags.
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle layer start (ignored unless idle)
//   kernel_size/stride/in_rows/in_ch_blk   layer configuration
//   pe_ready            PE back-pressure; low freezes the walk
//   buf_ren/buf_raddr   line-buffer read port
//   mask_tready/mask_reset                 selector beat and half toggle
//   acc_first/acc_last  row sideband, aligned to selector out_valid
//   busy/done/cfg_err   layer status
module act_sched #(
  parameter int PE_MAC  = act_sched_pkg::PE_MAC,
  parameter int RAM_ROW = act_sched_pkg::RAM_ROW,
  parameter int ADDR_W  = 9,
  parameter int SEL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        kernel_size,
  input  logic [1:0]        stride,
  input  logic [7:0]        in_rows,
  input  logic [5:0]        in_ch_blk,
  input  logic              pe_ready,
  output logic              buf_ren,
  output logic [ADDR_W-1:0] buf_raddr,
  output logic              mask_tready,
  output logic              mask_reset,
  output logic              acc_first,
  output logic              acc_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  import act_sched_pkg::*;

  // Selector window width bounds k at stride 1; never exceed the package cap.
  localparam int KMAX_FIT = RAM_ROW - (2 * PE_MAC - 1);
  localparam int KMAX_S1  = (KMAX_FIT < K_MAX_S1) ? KMAX_FIT : K_MAX_S1;

  state_t            state_q, state_d;
  logic [2:0]        k_q, k_d, beat_q, beat_d;
  logic [1:0]        s_q, s_d;
  logic [7:0]        h_q, h_d, r_q, r_d, drain_q, drain_d;
  logic [5:0]        c_q, c_d;
  logic              half_q, half_d;
  logic [8:0]        w_q, w_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic              done_q, done_d, err_q, err_d, busy_q, busy_d;

  logic [8:0]        wpr;
  logic [7:0]        out_rows;
  logic [ADDR_W-1:0] row_step, addr_nxt;
  logic              beat_go, last_beat, last_half, last_word, last_row;
  logic              word_end, layer_end, ovl_fetch;
  logic [1:0]        flags_raw, flags_dly;

  always_comb begin
    wpr       = 9'(k_q) * 9'(c_q);
    row_step  = ADDR_W'(s_q) * ADDR_W'(c_q);
    out_rows  = (s_q == 2'd2) ? ((h_q - {5'd0, k_q}) >> 1) + 8'd1
                              : (h_q - {5'd0, k_q}) + 8'd1;
    beat_go   = (state_q == BEAT) && pe_ready;
    last_beat = (beat_q == k_q - 3'd1);
    last_half = (s_q != 2'd1) || half_q;
    last_word = (w_q == wpr - 9'd1);
    last_row  = (r_q == out_rows - 8'd1);
    word_end  = last_beat && last_half;
    layer_end = word_end && last_word && last_row;
    // Address is a plain counter inside a row; a new row restarts at base+s*C.
    addr_nxt  = last_word ? base_q + row_step : addr_q + ADDR_W'(1);
    // Next word is requested on the current word's last beat so it lands
    // exactly as the following beat starts.
    ovl_fetch = beat_go && word_end && !layer_end;

    buf_ren     = (state_q == FETCH) || ovl_fetch;
    buf_raddr   = ovl_fetch ? addr_nxt : addr_q;
    mask_tready = beat_go;
    mask_reset  = beat_go && last_beat && (s_q == 2'd1);
    flags_raw   = {beat_go && (beat_q == 3'd0) && !half_q && (w_q == 9'd0),
                   beat_go && word_end && last_word};
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    h_d     = h_q;
    c_d     = c_q;
    beat_d  = beat_q;
    half_d  = half_q;
    w_d     = w_q;
    r_d     = r_q;
    base_d  = base_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        k_d     = kernel_size;
        s_d     = stride;
        h_d     = in_rows;
        c_d     = in_ch_blk;
        beat_d  = '0;
        half_d  = 1'b0;
        w_d     = '0;
        r_d     = '0;
        base_d  = '0;
        addr_d  = '0;
        state_d = CHECK;
      end
      CHECK: state_d = cfg_illegal(k_q, s_q, h_q, c_q, KMAX_S1) ? ERR : FETCH;
      FETCH: state_d = BEAT;
      BEAT: if (pe_ready) begin
        if (!last_beat) begin
          beat_d = beat_q + 3'd1;
        end else begin
          beat_d = '0;
          if (!last_half) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (layer_end) begin
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              addr_d = addr_nxt;
              if (last_word) begin
                w_d    = '0;
                r_d    = r_q + 8'd1;
                base_d = base_q + row_step;
              end else begin
                w_d = w_q + 9'd1;
              end
            end
          end
        end
      end
      DRAIN: begin
        if (int'(drain_q) >= SEL_LAT - 2) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d inside {FETCH, BEAT, DRAIN, ERR}) || done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      beat_q  <= '0;
      half_q  <= 1'b0;
      w_q     <= '0;
      r_q     <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      h_q     <= h_d;
      c_q     <= c_d;
      beat_q  <= beat_d;
      half_q  <= half_d;
      w_q     <= w_d;
      r_q     <= r_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  act_sched_dly #(.LAT(SEL_LAT)) u_dly (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (flags_raw),
    .q_o   (flags_dly)
  );

  assign acc_first = flags_dly[1];
  assign acc_last  = flags_dly[0];
  assign done      = done_q;
  assign cfg_err   = err_q;
  assign busy      = busy_q;

endmodule
